bitwise_op_pipe: RTL and testbench



---
 rtl/bitwise_op_pkg.sv | 33 +++
 rtl/bitwise_op_pipe_fifo.sv | 48 ++++
 rtl/bitwise_op_pipe.sv | 87 ++++++++
 tb/tb_bitwise_op_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bitwise_op_pkg.sv
// Shared types for bitwise_op_pipe: op codes, per-entry flag struct, and the
// reference op function. BITWISE_OP_PIPE_PARITY_EN adds a stored parity flag.
package bitwise_op_pkg;

  localparam int OP_MAX_W = 64;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_e;

  // Flags stored next to each FIFO result; the result field itself is sized by
  // the top-level WIDTH, so it is wrapped around this struct there.
  typedef struct packed {
    logic zero;
`ifdef BITWISE_OP_PIPE_PARITY_EN
    logic parity;
`endif
  } entry_flags_t;

  // Operates at the widest supported width; callers zero-extend operands and
  // truncate the result, which is exact because every op is purely bitwise.
  function automatic logic [OP_MAX_W-1:0] apply_op(input op_e op,
                                                   input logic [OP_MAX_W-1:0] a,
                                                   input logic [OP_MAX_W-1:0] b);
    logic [OP_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_op_pipe_fifo.sv
// Generic synchronous FIFO (W bits x DEPTH entries) with occupancy count.
// Storage is not reset; consumers must qualify dout with count != 0.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  // Guard against overflow/underflow even if a caller ignores full/empty.
  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bitwise_op_pipe.sv
// Handshaked bitwise AND/OR/XOR/NAND unit with a DEPTH-entry result FIFO and a
// saturating pop counter. Define BITWISE_OP_PIPE_PARITY_EN for out_parity.
module bitwise_op_pipe
  import bitwise_op_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
`ifdef BITWISE_OP_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    entry_flags_t     fl;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t           wr_entry, rd_entry;
  logic [WIDTH-1:0] res;
  logic [AW:0]      count;
  logic             push, pop, rdy_en;

  assign res = WIDTH'(apply_op(op_e'(in_op), OP_MAX_W'(in_a), OP_MAX_W'(in_b)));

  always_comb begin
    wr_entry         = '0;
    wr_entry.y       = res;
    wr_entry.fl.zero = ~|res;
`ifdef BITWISE_OP_PIPE_PARITY_EN
    wr_entry.fl.parity = ^res;
`endif
  end

  // Holds in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = rdy_en && (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (rd_entry),
    .count (count)
  );

  // Head storage is unreset, so outputs show reset values whenever empty.
  assign out_y    = out_valid ? rd_entry.y       : '0;
  assign out_zero = out_valid ? rd_entry.fl.zero : 1'b1;
`ifdef BITWISE_OP_PIPE_PARITY_EN
  assign out_parity = out_valid ? rd_entry.fl.parity : 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       op_count <= '0;
    else if (pop && (op_count != '1)) op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_bitwise_op_pipe.sv
// Scoreboard bench for bitwise_op_pipe: driver pushes hand-computed expected
// results into a queue, a negedge monitor pops and compares on each pop.
module tb_bitwise_op_pipe;
  import bitwise_op_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_y;
  logic       out_zero;
  logic [1:0] op_count;
`ifdef BITWISE_OP_PIPE_PARITY_EN
  logic       out_parity;
`endif

  bitwise_op_pipe #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
`ifdef BITWISE_OP_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] y;
    logic       z;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the next rising edge, so compare the head now.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got y=%0h with empty scoreboard at %0t", out_y, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_zero", 32'(out_zero), 32'(e.z));
`ifdef BITWISE_OP_PIPE_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(e.p));
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_op(input logic [3:0] a, input logic [3:0] b, input op_e op,
                         input logic [3:0] ey, input logic ez, input logic ep);
    bit done = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      logic rdy;
      @(negedge clk) rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        q.push_back('{y: ey, z: ez, p: ep});
        done = 1;
      end
    end
    if (!done) chk("push_timeout", 32'(0), 32'(1));
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (q.size() == 0 && !out_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Reset state.
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_y", 32'(out_y), 32'(0));
    chk("rst_out_zero", 32'(out_zero), 32'(1));
    chk("rst_op_count", 32'(op_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'(1));

    // AND with one-cycle latency, then op_count after the pop.
    out_ready = 1'b1;
    push_op(4'b0100, 4'b1100, OP_AND, 4'b0100, 1'b0, 1'b1);
    chk("latency_valid", 32'(out_valid), 32'(1));
    @(posedge clk); #1;
    chk("op_count_1", 32'(op_count), 32'(1));
    chk("empty_after_pop", 32'(out_valid), 32'(0));

    // OR/XOR/NAND back-to-back; CNT_W=2 so the count reaches 3 and holds.
    push_op(4'b0100, 4'b1100, OP_OR,   4'b1100, 1'b0, 1'b0);
    push_op(4'b0100, 4'b1100, OP_XOR,  4'b1000, 1'b0, 1'b1);
    push_op(4'b0100, 4'b1100, OP_NAND, 4'b1011, 1'b0, 1'b1);
    drain();
    chk("op_count_sat_a", 32'(op_count), 32'(3));

    // Zero flag and parity.
    push_op(4'b1010, 4'b0101, OP_AND, 4'b0000, 1'b1, 1'b0);
    push_op(4'b0111, 4'b1111, OP_AND, 4'b0111, 1'b0, 1'b1);
    drain();

    // Back-pressure: four fill the FIFO, the fifth is held until a pop.
    out_ready = 1'b0;
    push_op(4'b1111, 4'b0001, OP_AND,  4'b0001, 1'b0, 1'b1);
    push_op(4'b0001, 4'b0010, OP_OR,   4'b0011, 1'b0, 1'b0);
    push_op(4'b1111, 4'b0101, OP_XOR,  4'b1010, 1'b0, 1'b0);
    push_op(4'b1111, 4'b1111, OP_NAND, 4'b0000, 1'b1, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'(0));
    chk("full_out_valid", 32'(out_valid), 32'(1));
    fork
      push_op(4'b0110, 4'b0011, OP_XOR, 4'b0101, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("held_in_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-cycle with two entries queued: nothing stale may appear.
    out_ready = 1'b0;
    push_op(4'b0011, 4'b0101, OP_OR,  4'b0111, 1'b0, 1'b1);
    push_op(4'b0011, 4'b0101, OP_AND, 4'b0001, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_op_count", 32'(op_count), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    chk("midrst_out_zero", 32'(out_zero), 32'(1));
    q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_rel", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(out_valid), 32'(0));

    // op_count saturation over five pops.
    for (int i = 0; i < 5; i++) begin
      push_op(4'b0000, 4'b0000, OP_OR, 4'b0000, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("sat_count_%0d", i), 32'(op_count), 32'(sat_exp[i]));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
